hex_display_ctrl: RTL and testbench

HEX_DISPLAY_CTRL -- requirements
Module: hex_display_ctrl

---
 rtl/hex_display_pkg.sv | 21 ++
 rtl/hex_display_ctrl_decoder.sv | 11 +
 rtl/hex_display_ctrl.sv | 123 ++++++++++++
 tb/tb_hex_display_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// Shared types and segment constants for the seven-segment display controller.
// Segment patterns are active-low, bit 6 = g ... bit 0 = a.
package hex_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/hex_display_ctrl_decoder.sv
// Combinational nibble to active-low seven-segment decoder.
module hex_digit_decoder
  import hex_display_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb seg_o = SEG_TABLE[digit_i];

endmodule

// File: rtl/hex_display_ctrl.sv
// Binary to hex/decimal seven-segment display controller; decimal conversion
// runs a serial double-dabble, one bit per cycle.
module hex_display_ctrl
  import hex_display_pkg::*;
#(
  parameter int NDIGITS = 6,
  parameter int WIDTH   = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  input  logic             hex_mode,
  input  logic             blank_lz,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [6:0]       leds [NDIGITS]
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = 4 * NDIGITS;
  localparam logic [63:0] DEC_LIMIT = 64'(10 ** NDIGITS);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_adj;
  logic [WIDTH-1:0]   bin_q;
  logic               blank_q, ovf_pend_q;
  logic               done_q, ovf_q;
  logic [6:0]         leds_q   [NDIGITS];
  logic [6:0]         leds_d   [NDIGITS];
  logic [6:0]         seg_raw  [NDIGITS];
  logic [63:0]        val_ext;
  logic               cap_ovf;

  assign val_ext = 64'(value);

  always_comb begin
    if (hex_mode) cap_ovf = |(val_ext >> BCD_W);
    else          cap_ovf = (val_ext >= DEC_LIMIT);
  end

  always_comb begin
    bcd_adj = '0;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      else                         bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
    end
    bcd_d = {bcd_adj[BCD_W-2:0], bin_q[WIDTH-1]};
  end

  for (genvar g = 0; g < NDIGITS; g++) begin : g_dec
    hex_digit_decoder u_dec (
      .digit_i (bcd_q[4*g +: 4]),
      .seg_o   (seg_raw[g])
    );
  end

  // A digit is a leading zero when it and every digit above it are zero;
  // digit 0 is never blanked so a zero value still reads "0".
  always_comb begin
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      leds_d[i] = seg_raw[i];
      if (ovf_pend_q)
        leds_d[i] = SEG_DASH;
      else if (blank_q && (i != 0) && ((bcd_q >> (4*i)) == '0))
        leds_d[i] = SEG_BLANK;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bcd_q      <= '0;
      bin_q      <= '0;
      blank_q    <= 1'b0;
      ovf_pend_q <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      for (int unsigned i = 0; i < NDIGITS; i++) leds_q[i] <= SEG_BLANK;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            blank_q    <= blank_lz;
            ovf_pend_q <= cap_ovf;
            cnt_q      <= '0;
            if (hex_mode) begin
              bcd_q   <= val_ext[BCD_W-1:0];
              state_q <= DONE;
            end else begin
              bcd_q   <= '0;
              bin_q   <= value;
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          bcd_q <= bcd_d;
          bin_q <= bin_q << 1;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= DONE;
        end
        DONE: begin
          leds_q  <= leds_d;
          ovf_q   <= ovf_pend_q;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign overflow = ovf_q;
  assign leds     = leds_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Self-checking bench for hex_display_ctrl against an arithmetic reference model.
module tb_hex_display_ctrl;

  localparam int NDIGITS = 6;
  localparam int WIDTH   = 20;

  logic             clk = 1'b0;
  logic             reset, start, hex_mode, blank_lz;
  logic [WIDTH-1:0] value;
  logic             busy, done, overflow;
  logic [6:0]       leds [NDIGITS];
  logic [41:0]      dut_leds;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hex_display_ctrl #(.NDIGITS(NDIGITS), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .value    (value),
    .hex_mode (hex_mode),
    .blank_lz (blank_lz),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .leds     (leds)
  );

  always_comb begin
    dut_leds = '0;
    for (int i = 0; i < NDIGITS; i++) dut_leds[7*i +: 7] = leds[i];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;   1: return 7'b1111001;   2: return 7'b0100100;
      3: return 7'b0110000;   4: return 7'b0011001;   5: return 7'b0010010;
      6: return 7'b0000010;   7: return 7'b1111000;   8: return 7'b0000000;
      9: return 7'b0010000;  10: return 7'b0001000;  11: return 7'b0000011;
     12: return 7'b1000110;  13: return 7'b0100001;  14: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic exp_ovf(input logic [WIDTH-1:0] v, input logic hx);
    longint unsigned x;
    x = 64'(v);
    if (hx) return (x >> (4 * NDIGITS)) != 0;
    return x >= 64'd1000000;
  endfunction

  function automatic logic [41:0] exp_leds(input logic [WIDTH-1:0] v, input logic hx, input logic blz);
    longint unsigned x, p;
    int dig [NDIGITS];
    int msd;
    logic [41:0] r;
    x = 64'(v);
    p = 1;
    msd = 0;
    r = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (hx) dig[i] = int'((x >> (4 * i)) % 16);
      else    dig[i] = int'((x / p) % 10);
      p = p * 10;
      if (dig[i] != 0) msd = i;
    end
    for (int i = 0; i < NDIGITS; i++) begin
      if (exp_ovf(v, hx))       r[7*i +: 7] = 7'b0111111;
      else if (blz && i > msd)  r[7*i +: 7] = 7'b1111111;
      else                      r[7*i +: 7] = seg_of(dig[i]);
    end
    return r;
  endfunction

  // Reference: a pending result is released after a countdown of cycles.
  logic        m_valid = 1'b0;
  logic [41:0] m_leds, p_leds;
  logic        m_ovf, p_ovf, m_busy, m_done;
  int          m_cnt;

  always @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b1;
      m_leds  <= '1;
      m_ovf   <= 1'b0;
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_cnt   <= 0;
    end else if (m_valid) begin
      m_done <= 1'b0;
      if (!m_busy) begin
        if (start) begin
          p_leds <= exp_leds(value, hex_mode, blank_lz);
          p_ovf  <= exp_ovf(value, hex_mode);
          m_busy <= 1'b1;
          m_cnt  <= hex_mode ? 1 : WIDTH + 1;
        end
      end else if (m_cnt == 1) begin
        m_leds <= p_leds;
        m_ovf  <= p_ovf;
        m_done <= 1'b1;
        m_busy <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cyc_done", done, m_done);
      chk("cyc_busy", busy, m_busy);
      chk("cyc_overflow", overflow, m_ovf);
      chk("cyc_leds", dut_leds, m_leds);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic convert(input logic [WIDTH-1:0] v, input logic hx, input logic blz,
                         input bit noisy, output int lat);
    start    = 1'b1;
    value    = v;
    hex_mode = hx;
    blank_lz = blz;
    tick();
    start = 1'b0;
    lat   = 0;
    while (lat < 100) begin
      if (noisy) begin
        value    = WIDTH'($urandom);
        hex_mode = 1'($urandom);
        blank_lz = 1'($urandom);
        start    = 1'($urandom);
      end
      tick();
      lat++;
      if (done) break;
    end
    start = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, ndone;
    logic [WIDTH-1:0] v;
    logic hx, blz;

    reset = 1'b1; start = 1'b0; value = '0; hex_mode = 1'b0; blank_lz = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("reset_leds", dut_leds, {6{7'b1111111}});
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_ovf", overflow, 1'b0);

    convert(20'd123456, 1'b0, 1'b0, 1'b0, lat);
    chk("dec123456_lat", lat, 21);
    chk("dec123456_leds", dut_leds,
        {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010});
    chk("dec123456_ovf", overflow, 1'b0);

    convert(20'hABCDE, 1'b1, 1'b1, 1'b0, lat);
    chk("hexABCDE_lat", lat, 1);
    chk("hexABCDE_leds", dut_leds,
        {7'b1111111, 7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110});

    convert(20'd0, 1'b0, 1'b1, 1'b0, lat);
    chk("dec0_leds", dut_leds, {{5{7'b1111111}}, 7'b1000000});

    convert(20'd1000000, 1'b0, 1'b0, 1'b0, lat);
    chk("dec1e6_leds", dut_leds, {6{7'b0111111}});
    chk("dec1e6_ovf", overflow, 1'b1);

    convert(20'd999999, 1'b0, 1'b0, 1'b0, lat);
    chk("dec999999_leds", dut_leds, {6{7'b0010000}});
    chk("dec999999_ovf", overflow, 1'b0);

    // Second start mid-conversion must be ignored.
    start = 1'b1; value = 20'd777; hex_mode = 1'b0; blank_lz = 1'b0;
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1; value = 20'd12345; hex_mode = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done) ndone++;
    end
    chk("ignore_start_ndone", ndone, 1);
    chk("ignore_start_leds", dut_leds,
        {7'b1000000, 7'b1000000, 7'b1000000, 7'b1111000, 7'b1111000, 7'b1111000});

    // Reset in the middle of a conversion aborts it.
    start = 1'b1; value = 20'd314159; hex_mode = 1'b0; blank_lz = 1'b0;
    tick();
    start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_leds", dut_leds, {6{7'b1111111}});
    chk("abort_ovf", overflow, 1'b0);
    ndone = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (done) ndone++;
    end
    chk("abort_ndone", ndone, 0);
    convert(20'd42, 1'b0, 1'b1, 1'b0, lat);
    chk("after_abort_lat", lat, 21);
    chk("after_abort_leds", dut_leds, {{4{7'b1111111}}, 7'b0011001, 7'b0100100});

    for (int n = 0; n < 150; n++) begin
      case ($urandom % 4)
        0: v = WIDTH'($urandom % 100);
        1: v = WIDTH'(999990 + $urandom % 21);
        2: v = WIDTH'($urandom % 4096);
        default: v = WIDTH'($urandom);
      endcase
      hx  = 1'($urandom);
      blz = 1'($urandom);
      convert(v, hx, blz, 1'b1, lat);
      chk("rand_lat", lat, hx ? 1 : WIDTH + 1);
      chk("rand_leds", dut_leds, exp_leds(v, hx, blz));
      chk("rand_ovf", overflow, exp_ovf(v, hx));
      repeat ($urandom % 3) begin
        value = WIDTH'($urandom);
        tick();
      end
    end

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
